// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Holds the sequencer state encoding, op encoding and default geometry.
package alu_muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_GROUP = 4;

endpackage

// File: rtl/alu_muldiv_cla_adder.sv
// WIDTH-bit carry-lookahead adder: per-group P/G plus a flat group-carry network.
// Purely combinational; no state, no flow control.
module cla_adder #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NG = WIDTH / GROUP;

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] c;
   logic [NG-1:0]    gp;
   logic [NG-1:0]    gg;
   logic [NG:0]      gc;

   assign p = a ^ b;
   assign g = a & b;

   always_comb begin
      gp = '0;
      gg = '0;
      for (int k = 0; k < NG; k++) begin
         logic tg;
         logic tp;
         tg = 1'b0;
         tp = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            tg = g[k*GROUP+i] | (p[k*GROUP+i] & tg);
            tp = tp & p[k*GROUP+i];
         end
         gg[k] = tg;
         gp[k] = tp;
      end
   end

   // Each group carry is a flat sum of products over lower groups and cin.
   always_comb begin
      gc    = '0;
      gc[0] = cin;
      for (int k = 1; k <= NG; k++) begin
         logic acc;
         logic prod;
         acc  = 1'b0;
         prod = 1'b1;
         for (int j = k - 1; j >= 0; j--) begin
            acc  = acc | (prod & gg[j]);
            prod = prod & gp[j];
         end
         gc[k] = acc | (prod & cin);
      end
   end

   always_comb begin
      c = '0;
      for (int k = 0; k < NG; k++) begin
         logic cb;
         cb = gc[k];
         for (int i = 0; i < GROUP; i++) begin
            c[k*GROUP+i] = cb;
            cb = g[k*GROUP+i] | (p[k*GROUP+i] & cb);
         end
      end
   end

   assign sum  = p ^ c;
   assign cout = gc[NG];

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Shift-add multiply / non-restoring divide over one shared CLA; done WIDTH+2 cycles after start.
// No backpressure: start is ignored while busy; ALU_MULDIV_SIGNED_EN adds the sgn port for signed ops.
module alu_muldiv_sequencer
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GROUP = DEF_GROUP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ALU_MULDIV_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             op_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
   logic             rem_sign_q;

   logic             accept;
   logic             load_dbz;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             neg_lo;
   logic             neg_hi;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             new_sign;
   logic [WIDTH-1:0] rem_fix;

   assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
   assign load_dbz = accept && (op == OP_DIV) && (b == '0);

`ifdef ALU_MULDIV_SIGNED_EN
   logic sa, sb;
   logic neg_lo_q, neg_hi_q;

   assign sa     = sgn & a[WIDTH-1];
   assign sb     = sgn & b[WIDTH-1];
   assign a_mag  = sa ? (~a + 1'b1) : a;
   assign b_mag  = sb ? (~b + 1'b1) : b;
   assign neg_lo = neg_lo_q;
   assign neg_hi = neg_hi_q;

   // Product and quotient take the XOR of operand signs; remainder follows the dividend.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else if (accept) begin
         neg_lo_q <= sa ^ sb;
         neg_hi_q <= sa;
      end
   end
`else
   assign a_mag  = a;
   assign b_mag  = b;
   assign neg_lo = 1'b0;
   assign neg_hi = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = load_dbz ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == LAST) state_d = FIX;
         end
         FIX: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = accept ? (load_dbz ? DONE : RUN) : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Adder inputs stay at zero outside RUN/FIX so it never toggles while idle.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == RUN) begin
         if (op_q == OP_MUL) begin
            add_a = acc_hi_q;
            add_b = acc_lo_q[0] ? b_q : '0;
         end else begin
            add_a   = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            add_b   = rem_sign_q ? b_q : ~b_q;
            add_cin = ~rem_sign_q;
         end
      end else if (state_q == FIX) begin
         if ((op_q == OP_DIV) && rem_sign_q) begin
            add_a = acc_hi_q;
            add_b = b_q;
         end
      end
   end

   cla_adder #(
      .WIDTH(WIDTH),
      .GROUP(GROUP)
   ) u_cla (
      .a   (add_a),
      .b   (add_b),
      .cin (add_cin),
      .sum (add_sum),
      .cout(add_cout)
   );

   // Bit WIDTH of the partial remainder: shifted-in top bit plus extended addend plus carry.
   assign new_sign = acc_hi_q[WIDTH-1] ^ ~rem_sign_q ^ add_cout;
   assign rem_fix  = rem_sign_q ? add_sum : acc_hi_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= OP_MUL;
         b_q         <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         rem_sign_q  <= 1'b0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q        <= op;
            b_q         <= b_mag;
            acc_hi_q    <= '0;
            acc_lo_q    <= a_mag;
            rem_sign_q  <= 1'b0;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
            if (load_dbz) begin
               result_hi   <= a;
               result_lo   <= '1;
               div_by_zero <= 1'b1;
            end
         end else begin
            case (state_q)
               RUN: begin
                  cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                  if (op_q == OP_MUL) begin
                     {acc_hi_q, acc_lo_q} <= {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
                  end else begin
                     acc_hi_q   <= add_sum;
                     rem_sign_q <= new_sign;
                     acc_lo_q   <= {acc_lo_q[WIDTH-2:0], ~new_sign};
                  end
               end
               FIX: begin
                  if (op_q == OP_MUL) begin
                     {result_hi, result_lo} <= neg_lo ? (~{acc_hi_q, acc_lo_q} + 1'b1)
                                                      : {acc_hi_q, acc_lo_q};
                  end else begin
                     result_hi <= neg_hi ? (~rem_fix + 1'b1) : rem_fix;
                     result_lo <= neg_lo ? (~acc_lo_q + 1'b1) : acc_lo_q;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
